load_store_unit: RTL
====================

Name: load_store_unit

Overview:
Data-memory access stage directly downstream of the ALU in the rv32i core. It accepts one load/store per handshake: ALU-computed byte address, rs2 store data, funct3 and rd. It drives a word-addressed data memory with byte strobes over a valid/ready handshake. For loads it returns sign- or zero-extended write-back data to the register file; it stalls the core (req_ready low) while an access is outstanding.

Parameters:
XLEN, 32, data/address width (only 32 supported)
RD_W, 5, register index width

Ports:
clk  in  1  core clock
rst  in  1  reset, asynchronous, active-high
req_valid  in  1  core presents a memory instruction
req_ready  out  1  unit can accept a request this cycle
req_write  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I funct3 (width/sign)
req_addr  in  XLEN  byte address from ALU
req_wdata  in  XLEN  store data (rs2)
req_rd  in  RD_W  load destination register
resp_valid  out  1  one-cycle completion pulse
resp_we  out  1  register write enable (successful load only)
resp_rd  out  RD_W  destination register
resp_rdata  out  XLEN  extended load data
err_misaligned  out  1  valid with resp_valid: address misaligned for access size
err_illegal  out  1  valid with resp_valid: unsupported funct3
mem_valid  out  1  memory request
mem_ready  in  1  memory completes request this cycle
mem_we  out  1  write request
mem_wstrb  out  4  byte-lane write strobes
mem_addr  out  XLEN  word-aligned address ({req_addr[31:2],2'b00})
mem_wdata  out  XLEN  lane-replicated store data
mem_rdata  in  XLEN  read word, sampled when mem_valid && mem_ready && !mem_we

Behaviour:
- States: IDLE, ACCESS, DONE. Reset (async, any time) -> IDLE; all registered outputs 0: resp_*, err_*, mem_valid, mem_we, mem_wstrb, mem_addr, mem_wdata.
- req_ready = (state == IDLE), combinational from state.
- IDLE: on req_valid && req_ready, latch write, funct3, addr, wdata, rd. Check legality:
  - Loads: funct3 in {000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU}.
  - Stores: funct3 in {000 SB, 001 SH, 010 SW}.
  - Otherwise illegal.
- Alignment: H/HU require addr[0]==0; W requires addr[1:0]==0.
- Illegal or misaligned -> DONE directly, no memory access, matching err flag set (illegal has priority), resp_we=0.
- Otherwise -> ACCESS.
- ACCESS: mem_valid=1. mem_addr, mem_we, mem_wstrb, mem_wdata are held stable until mem_ready.
  - Strobes: B: 1<<addr[1:0]; H: 0011 or 1100 by addr[1]; W: 1111. Loads drive wstrb=0000.
  - wdata: SB {4{wdata[7:0]}}, SH {2{wdata[15:0]}}, SW wdata.
  - On mem_ready: loads capture the extracted lane into resp_rdata. B/BU select byte addr[1:0], H/HU select halfword addr[1]; B/H sign-extend, BU/HU zero-extend. -> DONE.
- DONE: resp_valid=1 for exactly one cycle. resp_we=1 only for a successful load. resp_rd = latched rd. resp_rdata=0 for stores/errors. -> IDLE. mem_valid is 0 in DONE.
- Minimum latency: accept at cycle N; mem_valid at N+1; with mem_ready at N+1, resp_valid at N+2, req_ready again at N+3. Error path: resp_valid at N+1.
- mem_ready while mem_valid=0 is ignored. A new request cannot be accepted in the same cycle as resp_valid.
- Reset mid-ACCESS drops mem_valid immediately (async); the memory must tolerate an abandoned request. No response is produced.

Decomposition:
- Shared package rv32i_pkg:
  - funct3 constants F3_LB/SB=3'b000, F3_LH/SH=3'b001, F3_LW/SW=3'b010, F3_LBU=3'b100, F3_LHU=3'b101.
  - lsu_state_t enum {LSU_IDLE, LSU_ACCESS, LSU_DONE}.
- One combinational sub-module lsu_align: inputs funct3, addr[1:0], store data, read word; outputs wstrb, replicated wdata, extended rdata, misaligned, illegal. The FSM stays in load_store_unit.

Test Plan:
- SW: addr 0x8, wdata 0x3FE, funct3 010, mem_ready same cycle as mem_valid -> mem_addr 0x8, wstrb 1111, mem_wdata 0x3FE, mem_we=1; resp_valid at N+2 with resp_we=0.
- LW: addr 0x8, rd 7, mem_rdata 0x3FE -> resp_rd 7, resp_rdata 0x000003FE, resp_we=1.
- LB vs LBU: addr 0x9, mem_rdata 0x1234F6AB -> LB resp_rdata 0xFFFFFFF6; LBU 0x000000F6.
- SH: addr 0x6, wdata 0xABCD1234 -> wstrb 1100, mem_wdata 0x12341234. Then LW at 0xA -> no mem_valid, resp_valid at N+1, err_misaligned=1, resp_we=0.
- Backpressure: hold mem_ready=0 for 5 cycles -> mem_valid and all mem_* stable, req_ready=0 throughout, a req_valid presented meanwhile is not accepted.
- Reset mid-ACCESS: assert rst while mem_valid=1 -> mem_valid=0 before the next clk edge, no resp_valid, req_ready=1 after release. funct3 011 load -> err_illegal=1, no memory access.

Source files
------------

// File: rtl/rv32i_pkg.sv
// rv32i shared definitions: funct3 encodings and load/store unit states.
package rv32i_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_ACCESS,
    LSU_DONE
  } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for rv32i loads/stores: strobes, store replication,
// load extraction/extension and legality/alignment checks.
module lsu_align
  import rv32i_pkg::*;
(
  input  logic        write_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misaligned_o,
  output logic        illegal_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rword_i[{addr_i, 3'b000} +: 8];
  assign half_sel = addr_i[1] ? rword_i[31:16] : rword_i[15:0];

  always_comb begin
    wstrb_o      = 4'b0000;
    wdata_o      = 32'h0;
    rdata_o      = 32'h0;
    misaligned_o = 1'b0;
    illegal_o    = 1'b0;
    case (funct3_i)
      F3_LB: begin
        wstrb_o = 4'b0001 << addr_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{byte_sel[7]}}, byte_sel};
      end
      F3_LH: begin
        misaligned_o = addr_i[0];
        wstrb_o = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{half_sel[15]}}, half_sel};
      end
      F3_LW: begin
        misaligned_o = |addr_i;
        wstrb_o = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = rword_i;
      end
      F3_LBU: begin
        illegal_o = write_i;
        rdata_o = {24'h0, byte_sel};
      end
      F3_LHU: begin
        illegal_o = write_i;
        misaligned_o = addr_i[0];
        rdata_o = {16'h0, half_sel};
      end
      default: illegal_o = 1'b1;
    endcase
    // loads never write: no strobes, no store data
    if (!write_i) begin
      wstrb_o = 4'b0000;
      wdata_o = 32'h0;
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// rv32i data-memory stage: one load/store per handshake, word-addressed
// memory with byte strobes, extended write-back data for loads.
module load_store_unit
  import rv32i_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [RD_W-1:0] req_rd,
  output logic            resp_valid,
  output logic            resp_we,
  output logic [RD_W-1:0] resp_rd,
  output logic [XLEN-1:0] resp_rdata,
  output logic            err_misaligned,
  output logic            err_illegal,
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic            mem_we,
  output logic [3:0]      mem_wstrb,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
);

  lsu_state_t      state_q;
  logic            write_q;
  logic [2:0]      funct3_q;
  logic [1:0]      addr_lo_q;
  logic [RD_W-1:0] rd_q;

  logic            idle;
  logic            a_write;
  logic [2:0]      a_f3;
  logic [1:0]      a_lo;
  logic [3:0]      a_wstrb;
  logic [XLEN-1:0] a_wdata;
  logic [XLEN-1:0] a_rdata;
  logic            a_mis;
  logic            a_ill;

  assign idle      = (state_q == LSU_IDLE);
  assign req_ready = idle;

  // aligner sees the live request in IDLE, the latched one afterwards
  assign a_write = idle ? req_write        : write_q;
  assign a_f3    = idle ? req_funct3       : funct3_q;
  assign a_lo    = idle ? req_addr[1:0]    : addr_lo_q;

  lsu_align u_align (
    .write_i      (a_write),
    .funct3_i     (a_f3),
    .addr_i       (a_lo),
    .wdata_i      (req_wdata),
    .rword_i      (mem_rdata),
    .wstrb_o      (a_wstrb),
    .wdata_o      (a_wdata),
    .rdata_o      (a_rdata),
    .misaligned_o (a_mis),
    .illegal_o    (a_ill)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= LSU_IDLE;
      write_q        <= 1'b0;
      funct3_q       <= '0;
      addr_lo_q      <= '0;
      rd_q           <= '0;
      resp_valid     <= 1'b0;
      resp_we        <= 1'b0;
      resp_rd        <= '0;
      resp_rdata     <= '0;
      err_misaligned <= 1'b0;
      err_illegal    <= 1'b0;
      mem_valid      <= 1'b0;
      mem_we         <= 1'b0;
      mem_wstrb      <= '0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
    end else begin
      unique case (state_q)
        LSU_IDLE: begin
          if (req_valid) begin
            write_q   <= req_write;
            funct3_q  <= req_funct3;
            addr_lo_q <= req_addr[1:0];
            rd_q      <= req_rd;
            if (a_ill || a_mis) begin
              state_q        <= LSU_DONE;
              resp_valid     <= 1'b1;
              resp_we        <= 1'b0;
              resp_rd        <= req_rd;
              resp_rdata     <= '0;
              err_illegal    <= a_ill;
              err_misaligned <= !a_ill;
            end else begin
              state_q   <= LSU_ACCESS;
              mem_valid <= 1'b1;
              mem_we    <= req_write;
              mem_wstrb <= a_wstrb;
              mem_addr  <= {req_addr[XLEN-1:2], 2'b00};
              mem_wdata <= a_wdata;
            end
          end
        end
        LSU_ACCESS: begin
          if (mem_ready) begin
            state_q    <= LSU_DONE;
            mem_valid  <= 1'b0;
            resp_valid <= 1'b1;
            resp_we    <= !write_q;
            resp_rd    <= rd_q;
            resp_rdata <= write_q ? '0 : a_rdata;
          end
        end
        LSU_DONE: begin
          state_q        <= LSU_IDLE;
          resp_valid     <= 1'b0;
          resp_we        <= 1'b0;
          resp_rd        <= '0;
          resp_rdata     <= '0;
          err_misaligned <= 1'b0;
          err_illegal    <= 1'b0;
        end
        default: state_q <= LSU_IDLE;
      endcase
    end
  end

endmodule
